// File: rtl/mplier_seq16x16_pkg.sv
// Shared definitions for the sequential limb multiplier: limb width, FSM states, counter sizing.
package mplier_seq16x16_pkg;

    localparam int LIMB_W = 8;

    // Encoding 2'd3 is unused and returns to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int limbs);
        return (limbs > 1) ? $clog2(limbs) : 1;
    endfunction

endpackage

// File: rtl/mplier_seq16x16_mplieru8x8.sv
// Combinational unsigned 8x8 multiplier shared by the sequential wide multiplier.
module mplieru8x8 (
    output logic [15:0] product,
    input  logic [7:0]  a,
    input  logic [7:0]  b
);

    assign product = 16'(a) * 16'(b);

endmodule

// File: rtl/mplier_seq16x16.sv
// Multi-cycle unsigned OPW x OPW multiplier: one 8x8 partial product per cycle, shift-accumulated.
module mplier_seq16x16
    import mplier_seq16x16_pkg::*;
#(
    parameter int OPW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_a,
    input  logic [OPW-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*OPW-1:0] out_product,
    output logic             busy
);

    localparam int L  = OPW / LIMB_W;
    localparam int IW = cnt_w(L);
    localparam logic [IW-1:0] LAST = IW'(L - 1);

    if ((OPW % LIMB_W) != 0 || OPW < LIMB_W) begin : g_bad_opw
        $error("mplier_seq16x16: OPW must be a multiple of 8 and at least 8");
    end

    state_t            state;
    logic [IW-1:0]     i, j;
    logic [OPW-1:0]    a_r, b_r;
    logic [2*OPW-1:0]  acc;
    logic [LIMB_W-1:0] a_limb, b_limb;
    logic [15:0]       pp;
    logic [2*OPW-1:0]  pp_sh;
    logic [2*OPW-1:0]  acc_next;

    always_comb begin
        a_limb   = LIMB_W'(a_r >> (LIMB_W * int'(i)));
        b_limb   = LIMB_W'(b_r >> (LIMB_W * int'(j)));
        pp_sh    = (2*OPW)'(pp) << (LIMB_W * (int'(i) + int'(j)));
        acc_next = acc + pp_sh;
    end

    mplieru8x8 u_mul (
        .product (pp),
        .a       (a_limb),
        .b       (b_limb)
    );

    // Combinational in out_ready so a retiring result and a new accept share one edge.
    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            i           <= '0;
            j           <= '0;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc <= acc_next;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            i           <= '0;
                            out_valid   <= 1'b1;
                            out_product <= acc_next;
                            state       <= ST_DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_r   <= in_a;
                            b_r   <= in_b;
                            acc   <= '0;
                            i     <= '0;
                            j     <= '0;
                            state <= ST_MUL;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
